// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared constants and types for the IF/ID hazard controller.
package if_id_hazard_ctrl_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0 -- what a flushed IF/ID slot holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// Pipeline-side signals of the IF/ID hazard controller: hazard sources in, register enables out.
interface if_id_hazard_ctrl_if #(
  parameter int REG_ADDR_W = if_id_hazard_ctrl_pkg::REG_ADDR_W
);
  import if_id_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_redirect;
  logic                  ex_mc_start;
  logic                  imem_ready;

  logic                  pc_we;
  logic                  ifid_we;
  logic                  ifid_flush;
  logic                  idex_we;
  logic                  idex_flush;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, ex_mc_start, imem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_redirect, ex_mc_start, imem_ready,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush
  );

endinterface

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-low clear, used for debug performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Front-end sequencer: decides advance / hold / flush of PC and IF/ID, bubble / freeze of ID/EX.
//
//   state   | meaning
//   HOLD    | in or just out of reset; front end flushed, nothing fetched
//   RUN     | normal issue; resolves redirect, mul/div start, load-use, fetch wait
//   MC_WAIT | multi-cycle EX op in flight; whole front end frozen
module if_id_hazard_ctrl #(
  parameter int WORD_WIDTH = if_id_hazard_ctrl_pkg::WORD_WIDTH,
  parameter int REG_ADDR_W = if_id_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int MC_CYCLES  = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  if_id_hazard_ctrl_if.slave    bus,
  output logic [WORD_WIDTH-1:0] stall_cnt,
  output logic [WORD_WIDTH-1:0] flush_cnt
);
  import if_id_hazard_ctrl_pkg::*;

  // Wait cycles spent in MC_WAIT; the start cycle is the other frozen cycle.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 2);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      mc_cnt, mc_cnt_nxt;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                  load_use;
  logic                  pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic                  redirect_cyc;
  logic                  stall_en;

  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;
  assign ex_rd  = bus.ex_rd;

  assign load_use = bus.ex_mem_read && (ex_rd != '0) &&
                    ((bus.id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (bus.id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= HOLD;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mc_cnt_nxt   = mc_cnt;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_we      = 1'b0;
    idex_flush   = 1'b0;
    redirect_cyc = 1'b0;

    case (state)
      HOLD: begin
        ifid_flush = 1'b1;
        idex_we    = 1'b1;
        idex_flush = 1'b1;
        state_nxt  = RUN;
      end

      RUN: begin
        if (bus.ex_redirect) begin
          redirect_cyc = 1'b1;
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          ifid_flush   = 1'b1;
          idex_we      = 1'b1;
          idex_flush   = 1'b1;
        end else if (bus.ex_mc_start) begin
          mc_cnt_nxt = MC_LOAD;
          state_nxt  = (MC_LOAD == '0) ? RUN : MC_WAIT;
        end else if (load_use) begin
          idex_we    = 1'b1;
          idex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_we    = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          idex_we = 1'b1;
        end
      end

      MC_WAIT: begin
        if (bus.ex_redirect) begin
          redirect_cyc = 1'b1;
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          ifid_flush   = 1'b1;
          idex_we      = 1'b1;
          idex_flush   = 1'b1;
          mc_cnt_nxt   = '0;
          state_nxt    = RUN;
        end else begin
          // Leave on the cycle the count reaches zero so mc_cnt rests at 0 in RUN.
          mc_cnt_nxt = mc_cnt - CNT_W'(1);
          if (mc_cnt_nxt == '0) begin
            state_nxt = RUN;
          end
        end
      end

      default: begin
        ifid_flush = 1'b1;
        idex_we    = 1'b1;
        idex_flush = 1'b1;
        mc_cnt_nxt = '0;
        state_nxt  = HOLD;
      end
    endcase
  end

  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = ifid_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_we    = idex_we;
  assign bus.idex_flush = idex_flush;

  assign stall_en = ((state == RUN) || (state == MC_WAIT)) && !pc_we;

  sat_counter #(.WIDTH(WORD_WIDTH)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.WIDTH(WORD_WIDTH)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (redirect_cyc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench: a wide-counter and a narrow-counter instance share random stimulus.
module tb_if_id_hazard_ctrl;
  import if_id_hazard_ctrl_pkg::*;

  localparam int MC = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_hazard_ctrl_if bus_a ();
  if_id_hazard_ctrl_if bus_b ();

  logic [WORD_WIDTH-1:0] stall_a, flush_a;
  logic [SW-1:0]         stall_b, flush_b;

  if_id_hazard_ctrl #(.MC_CYCLES(MC)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.slave),
    .stall_cnt (stall_a),
    .flush_cnt (flush_a)
  );

  if_id_hazard_ctrl #(.WORD_WIDTH(SW), .MC_CYCLES(MC)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b.slave),
    .stall_cnt (stall_b),
    .flush_cnt (flush_b)
  );

  // ctrl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush}
  typedef struct {
    int         idx;
    logic [4:0] ctrl;
    longint     stall;
    longint     flush;
  } exp_t;

  exp_t q[$];
  int vectors     = 0;
  int miscompares = 0;
  int step_no     = 0;

  // Reference model: pending-hold flag, remaining frozen wait cycles, unbounded event counts
  bit     m_hold      = 1'b1;
  int     m_wait_left = 0;
  longint m_stall     = 0;
  longint m_flush     = 0;

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                      input logic redir, input logic mc, input logic ready);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = r;
    bus_a.id_rs1 = rs1;  bus_b.id_rs1 = rs1;
    bus_a.id_rs2 = rs2;  bus_b.id_rs2 = rs2;
    bus_a.id_uses_rs1 = u1;  bus_b.id_uses_rs1 = u1;
    bus_a.id_uses_rs2 = u2;  bus_b.id_uses_rs2 = u2;
    bus_a.ex_mem_read = mr;  bus_b.ex_mem_read = mr;
    bus_a.ex_rd = rd;  bus_b.ex_rd = rd;
    bus_a.ex_redirect = redir;  bus_b.ex_redirect = redir;
    bus_a.ex_mc_start = mc;  bus_b.ex_mc_start = mc;
    bus_a.imem_ready = ready;  bus_b.imem_ready = ready;

    hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

    if (!r) begin
      m_hold = 1'b1; m_wait_left = 0; m_stall = 0; m_flush = 0;
    end
    e.idx   = step_no;
    e.stall = m_stall;
    e.flush = m_flush;

    if (!r || m_hold) begin
      e.ctrl = 5'b00111;
      if (r) m_hold = 1'b0;
    end else if (redir) begin
      e.ctrl = 5'b11111; m_flush++; m_wait_left = 0;
    end else if (m_wait_left > 0) begin
      e.ctrl = 5'b00000; m_stall++; m_wait_left--;
    end else if (mc) begin
      e.ctrl = 5'b00000; m_stall++; m_wait_left = MC - 2;
    end else if (hz) begin
      e.ctrl = 5'b00011; m_stall++;
    end else if (!ready) begin
      e.ctrl = 5'b01110; m_stall++;
    end else begin
      e.ctrl = 5'b11010;
    end
    q.push_back(e);
    step_no++;
  endtask

  task automatic idle(input logic r);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  exp_t m_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("ctrl_a", m_e.idx, {bus_a.pc_we, bus_a.ifid_we, bus_a.ifid_flush,
                              bus_a.idex_we, bus_a.idex_flush}, m_e.ctrl);
      chk("ctrl_b", m_e.idx, {bus_b.pc_we, bus_b.ifid_we, bus_b.ifid_flush,
                              bus_b.idex_we, bus_b.idex_flush}, m_e.ctrl);
      chk("stall_a", m_e.idx, stall_a, sat(m_e.stall, WORD_WIDTH));
      chk("flush_a", m_e.idx, flush_a, sat(m_e.flush, WORD_WIDTH));
      chk("stall_b", m_e.idx, stall_b, sat(m_e.stall, SW));
      chk("flush_b", m_e.idx, flush_b, sat(m_e.flush, SW));
    end
  end

  initial begin
    int drain;
    rst = 1'b0;
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    // load-use on rs2, then ex_rd==0 never hazards
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    // redirect outranks load-use
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    // multi-cycle op, plain and interrupted by reset
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);
    repeat (3) idle(1'b1);
    // redirect aborting a wait
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    // fetch wait, then a long run of stalls to saturate the narrow counters
    repeat (2) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    repeat (10) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 4) != 0));
    end

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge clk);
      #1;
      drain++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
